// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory responder.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DMEM_ERR_DEFAULT = 32'h0;

endpackage

// File: rtl/dmem_array.sv
// Word-wide single-port storage: synchronous write, synchronous read.
// The contents are not reset.
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-first port: the read returns the old word on the edge that writes it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder behind the memory-stage interface.
// It latches a request in IDLE, waits LATENCY cycles in BUSY, commits, and
// then spends one DONE cycle in which the stall drops so the pipeline advances.
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] ERR_DATA = DMEM_ERR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemErrM
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LSB = $clog2(WORD_BYTES);

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [AW-1:0] in_idx;
    logic          in_err;
    logic          arr_we;
    logic [AW-1:0] arr_addr;
    logic [31:0]   arr_rdata;

    // Decode the incoming byte address: word index plus misalign/range error.
    always_comb begin
        in_idx = ALUOutM[AW+LSB-1:LSB];
        in_err = (ALUOutM[LSB-1:0] != '0) || (ALUOutM[31:AW+LSB] != '0);
    end

    // While idle the array looks at the incoming address so the read data is
    // already in flight on the latching edge; LATENCY=1 depends on this.
    assign arr_addr = (state_q == IDLE) ? in_idx : idx_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Next-state logic: latch in IDLE, count down in BUSY, commit on the last
    // BUSY edge; a dropped request in BUSY is a flush and commits nothing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        arr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemReqM) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    idx_d   = in_idx;
                    err_d   = in_err;
                    we_d    = MemWriteM;
                    wdata_d = WriteDataM;
                end
            end
            BUSY: begin
                if (!MemReqM) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (we_q) begin
                        arr_we = !err_q;
                    end else begin
                        rdata_d = err_q ? ERR_DATA : arr_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign ReadDataM = rdata_q;
    assign MemStallM = MemReqM && (state_q != DONE);
    assign MemErrM   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance (index 0) and a
// LATENCY=1 instance (index 1) sharing clock and reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        stall [2];
    logic        err   [2];

    int ntests = 0;
    int nfail  = 0;

    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(2), .ERR_DATA(ERRV)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .MemReqM    (req[0]),
        .MemWriteM  (we[0]),
        .ALUOutM    (addr[0]),
        .WriteDataM (wd[0]),
        .ReadDataM  (rd[0]),
        .MemStallM  (stall[0]),
        .MemErrM    (err[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1), .ERR_DATA(32'h0)) dut1 (
        .clk        (clk),
        .reset      (rst_n),
        .MemReqM    (req[1]),
        .MemWriteM  (we[1]),
        .ALUOutM    (addr[1]),
        .WriteDataM (wd[1]),
        .ReadDataM  (rd[1]),
        .MemStallM  (stall[1]),
        .MemErrM    (err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on instance s starting in the current (IDLE) cycle.
    // Counts stall cycles, captures err/rdata in DONE, releases the request.
    // With chg set, address/data/write are disturbed after the latching edge.
    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit chg,
                          output int nst, output logic e, output logic [31:0] r);
        bit done;
        done   = 0;
        nst    = 0;
        e      = 1'bx;
        r      = 'x;
        req[s] = 1'b1;
        we[s]  = w;
        addr[s] = a;
        wd[s]  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (stall[s]) nst++;
            else begin
                done = 1;
                e = err[s];
                r = rd[s];
            end
            if (chg && i == 0) begin
                @(posedge clk); #1;
                addr[s] = a + 32'h4;
                wd[s]   = 32'h9999_9999;
                we[s]   = ~w;
            end
        end
        chk("done_in_budget", 32'(done), 32'd1);
        @(posedge clk); #1;
        req[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nst;
        logic        e;
        logic [31:0] r;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0;
        end
        repeat (2) @(posedge clk); #1;
        chk("rst_rdata", rd[0], 32'h0);
        chk("rst_stall", 32'(stall[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        req[0] = 1'b1; #1;
        chk("rst_stall_follows_req", 32'(stall[0]), 32'd1);
        chk("rst_err_req", 32'(err[0]), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload and load back
        access(0, 1'b1, 32'h0C, 32'hA5A5_0003, 0, nst, e, r);
        chk("st0c_stall", 32'(nst), 32'd3);
        chk("st0c_err", 32'(e), 32'd0);
        access(0, 1'b0, 32'h0C, 32'h0, 0, nst, e, r);
        chk("ld0c_stall", 32'(nst), 32'd3);
        chk("ld0c_data", r, 32'hA5A5_0003);
        chk("ld0c_err", 32'(e), 32'd0);

        // Back-to-back store then load
        access(0, 1'b1, 32'h10, 32'h1234_5678, 0, nst, e, r);
        chk("st10_stall", 32'(nst), 32'd3);
        access(0, 1'b0, 32'h10, 32'h0, 0, nst, e, r);
        chk("ld10_stall", 32'(nst), 32'd3);
        chk("ld10_data", r, 32'h1234_5678);
        chk("rdata_held", rd[0], 32'h1234_5678);

        // Known contents for the error and abort checks
        access(0, 1'b1, 32'h04, 32'h0101_0101, 0, nst, e, r);
        access(0, 1'b1, 32'h00, 32'h0000_0077, 0, nst, e, r);
        access(0, 1'b1, 32'h20, 32'h1111_0008, 0, nst, e, r);

        // Misaligned load and store
        access(0, 1'b0, 32'h06, 32'h0, 0, nst, e, r);
        chk("mis_ld_err", 32'(e), 32'd1);
        chk("mis_ld_data", r, ERRV);
        chk("mis_ld_stall", 32'(nst), 32'd3);
        chk("err_one_cycle", 32'(err[0]), 32'd0);
        access(0, 1'b1, 32'h06, 32'hFFFF_FFFF, 0, nst, e, r);
        chk("mis_st_err", 32'(e), 32'd1);
        access(0, 1'b0, 32'h04, 32'h0, 0, nst, e, r);
        chk("mis_st_nowrite", r, 32'h0101_0101);
        chk("mis_st_ld_err", 32'(e), 32'd0);

        // Out-of-range store (word index aliases mem[0])
        access(0, 1'b1, 32'h100, 32'h0000_CAFE, 0, nst, e, r);
        chk("oor_st_err", 32'(e), 32'd1);
        access(0, 1'b0, 32'h00, 32'h0, 0, nst, e, r);
        chk("oor_st_nowrite", r, 32'h0000_0077);

        // Reset in the commit cycle of a store
        access(0, 1'b0, 32'h0C, 32'h0, 0, nst, e, r);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hDEAD_0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_rdata", rd[0], 32'h0);
        chk("midrst_stall", 32'(stall[0]), 32'd1);
        chk("midrst_err", 32'(err[0]), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(0, 1'b0, 32'h20, 32'h0, 0, nst, e, r);
        chk("midrst_nowrite", r, 32'h1111_0008);

        // Flush: request dropped in the last BUSY cycle
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h00; wd[0] = 32'hBAD0_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[0] = 1'b0; #1;
        chk("flush_stall", 32'(stall[0]), 32'd0);
        @(posedge clk); #1;
        access(0, 1'b0, 32'h00, 32'h0, 0, nst, e, r);
        chk("flush_nowrite", r, 32'h0000_0077);
        chk("flush_ld_stall", 32'(nst), 32'd3);

        // LATENCY=1 instance
        access(1, 1'b1, 32'h0C, 32'h0000_0033, 0, nst, e, r);
        chk("l1_st_stall", 32'(nst), 32'd2);
        access(1, 1'b1, 32'h08, 32'h0000_0055, 1, nst, e, r);
        chk("l1_chg_stall", 32'(nst), 32'd2);
        chk("l1_chg_err", 32'(e), 32'd0);
        access(1, 1'b0, 32'h08, 32'h0, 0, nst, e, r);
        chk("l1_latched_data", r, 32'h0000_0055);
        chk("l1_ld_stall", 32'(nst), 32'd2);
        access(1, 1'b0, 32'h0C, 32'h0, 0, nst, e, r);
        chk("l1_other_word", r, 32'h0000_0033);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the far side of the pipeline's memory-stage interface.
- The datapath issues a request: word address from ALUOutM, store data from WriteDataM, a request strobe and a write enable.
- This block services the request after a fixed latency, returns ReadDataM and holds MemStallM high until the access completes. The hazard unit uses MemStallM to freeze F/D/E/M.
- Backing store is an internal word-addressed register array.

Parameters:
- DEPTH, 64: number of 32-bit words in the backing store (power of 2).
- LATENCY, 2: BUSY-state cycles before the access commits; legal range 1..15.
- ERR_DATA, 32'h0: value driven on ReadDataM after an errored read.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- MemReqM  input  1  memory-stage instruction is a load or store.
- MemWriteM  input  1  1 = store, 0 = load; valid while MemReqM=1.
- ALUOutM  input  32  byte address.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data; registered; held until the next completed access.
- MemStallM  output  1  1 = access not yet complete; the pipeline must hold the memory-stage request stable.
- MemErrM  output  1  one-cycle flag in DONE: misaligned or out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE, counter=0, ReadDataM=0.
  - MemStallM and MemErrM are driven by the combinational equations below. With reset asserted, MemStallM follows MemReqM and MemErrM=0.
  - Array contents are not cleared.
  - Reset during BUSY aborts the access; no write occurs.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if MemReqM=1, latch address, write data and write enable; counter<=LATENCY-1; go to BUSY. Otherwise stay.
  - BUSY, counter!=0: counter<=counter-1.
  - BUSY, counter==0: commit the access at this edge and go to DONE.
    - Store: mem[idx]<=latched data.
    - Load: ReadDataM<=mem[idx].
  - BUSY, MemReqM dropped (flush): return to IDLE with no commit.
  - DONE: unconditionally go to IDLE. This is the cycle the pipeline advances. A request seen in the following IDLE cycle is treated as new.
- MemStallM = MemReqM && (state != DONE). This is combinational, so the stall asserts in the same cycle the request first appears.
- Timing: a request presented in cycle t sees MemStallM=1 for cycles t..t+LATENCY and 0 at t+LATENCY+1 (DONE). That is LATENCY+1 stall cycles.
- ReadDataM is valid from the DONE cycle onward, until the next load commit.
- Address decode: idx = addr[log2(DEPTH)+1:2].
  - Error if addr[1:0]!=0 or addr[31:log2(DEPTH)+2]!=0.
  - Errored store: no array write.
  - Errored load: ReadDataM<=ERR_DATA.
  - MemErrM=1 only during the DONE cycle of an errored access, 0 otherwise.
- Store followed by load to the same word: the load returns the stored value, because the store commits before the next IDLE.
- MemWriteM, ALUOutM and WriteDataM are sampled only in IDLE. Changes during BUSY are ignored; the latched copy is used.
- No byte enables; all accesses are full-word.

Decomposition:
- Shared package (cpu_pkg):
  - typedef enum dmem_state_t {IDLE, BUSY, DONE}.
  - Constants WORD_BYTES=4 and DMEM_ERR_DEFAULT.
- One sub-module: dmem_array (DEPTH x 32, single port, synchronous write, synchronous read, write enable). It holds the storage only; the FSM and decode stay in dmem_responder.

Test Plan:
- Load after reset, LATENCY=2, DEPTH=64: preload mem[3]=32'hA5A5_0003 via a store to 0x0C; then load 0x0C. Required: MemStallM high for exactly 3 cycles, low in DONE, ReadDataM=32'hA5A5_0003, MemErrM=0.
- Back-to-back store 0x10 <- 32'h1234_5678, then load 0x10 in the next request. Required: ReadDataM=32'h1234_5678; each request stalls 3 cycles; one IDLE cycle separates the two.
- Misaligned load at 0x0000_0006. Required: MemErrM=1 for one cycle in DONE, ReadDataM=ERR_DATA. Misaligned store at 0x06 of 32'hFFFF_FFFF leaves mem[1] unchanged.
- Out-of-range store at 0x0000_0100 (DEPTH=64). Required: MemErrM=1 in DONE; a subsequent load of 0x00 returns its prior value.
- reset pulsed low mid-BUSY during a store of 32'hDEAD_0001 to 0x20. Required: state IDLE, ReadDataM=0 immediately, and mem[8] retains its prior value. Also: MemReqM dropped mid-BUSY returns to IDLE with no write.
- LATENCY=1 build: a request stalls exactly 2 cycles. Changing ALUOutM and WriteDataM while BUSY has no effect; the latched values commit.
